// File: rtl/hit_judge_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hit_judge_controller_pkg
//  Purpose  : Shared judge codes, FSM state encoding and note-kind constants
//             for the drum hit judge controller.
//  Revision : 1.0 - initial release
// ============================================================================
package hit_judge_controller_pkg;

   // Result codes reported on the judge output
   localparam logic [1:0] JUDGE_NONE  = 2'b00;
   localparam logic [1:0] JUDGE_GOOD  = 2'b01;
   localparam logic [1:0] JUDGE_MISS  = 2'b10;
   localparam logic [1:0] JUDGE_WRONG = 2'b11;

   // Note kinds as carried on note_kind
   localparam logic KIND_DON = 1'b0;
   localparam logic KIND_KA  = 1'b1;

   // Controller states; resolution states last exactly one cycle
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ARMED = 3'd1,
      ST_GOOD  = 3'd2,
      ST_WRONG = 3'd3,
      ST_MISS  = 3'd4
   } state_t;

endpackage : hit_judge_controller_pkg
`default_nettype wire

// File: rtl/rise_edge_detect.sv
`default_nettype none
// ============================================================================
//  Module   : rise_edge_detect
//  Purpose  : 1-bit rising-edge detector; a held level never re-triggers.
//  Revision : 1.0 - initial release
// ============================================================================
module rise_edge_detect (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic rise
);

   logic r_din_q;

   // Previous sample of the (already synchronised) input level
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_din_q <= 1'b0;
      else       r_din_q <= din;
   end

   assign rise = din & ~r_din_q;

endmodule : rise_edge_detect
`default_nettype wire

// File: rtl/hit_judge_controller.sv
`default_nettype none
// ============================================================================
//  Module   : hit_judge_controller
//  Purpose  : Opens a timing window per note at the hit line, judges don/ka
//             presses as good/wrong/miss, pulses the score counter and keeps
//             a saturating combo count.
//  Revision : 1.0 - initial release
// ============================================================================
module hit_judge_controller
   import hit_judge_controller_pkg::*;
#(
   parameter int WINDOW  = 4,
   parameter int COMBO_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               tick,
   input  logic               note_valid,
   input  logic               note_kind,
   input  logic               don_btn,
   input  logic               ka_btn,
   output logic               increase_score,
   output logic               decrease_score,
   output logic [COMBO_W-1:0] combo,
   output logic [1:0]         judge,
   output logic               busy
);

   localparam logic [3:0]         c_WINDOW    = 4'(WINDOW);
   localparam logic [COMBO_W-1:0] c_COMBO_MAX = {COMBO_W{1'b1}};

   // Registered state
   state_t             r_state;
   logic               r_cur_kind;
   logic [3:0]         r_win_cnt;
   logic               r_pend_valid;
   logic               r_pend_kind;
   logic               r_cur_loaded;   // current slot already refilled during a forced shift
   logic [COMBO_W-1:0] r_combo;
   logic [1:0]         r_judge;

   // Next-state values
   state_t             w_state;
   logic               w_cur_kind;
   logic [3:0]         w_win_cnt;
   logic               w_pend_valid;
   logic               w_pend_kind;
   logic               w_cur_loaded;
   logic [COMBO_W-1:0] w_combo;
   logic [1:0]         w_judge;

   logic w_don_rise;
   logic w_ka_rise;
   logic w_arrival;
   logic w_press_kind;

   rise_edge_detect u_don_edge (
      .clk   (clk),
      .reset (reset),
      .din   (don_btn),
      .rise  (w_don_rise)
   );

   rise_edge_detect u_ka_edge (
      .clk   (clk),
      .reset (reset),
      .din   (ka_btn),
      .rise  (w_ka_rise)
   );

   assign w_arrival    = tick & note_valid;
   assign w_press_kind = w_don_rise ? KIND_DON : KIND_KA;

   // Next-state, note queue and score bookkeeping
   always_comb begin
      w_state      = r_state;
      w_cur_kind   = r_cur_kind;
      w_win_cnt    = r_win_cnt;
      w_pend_valid = r_pend_valid;
      w_pend_kind  = r_pend_kind;
      w_cur_loaded = r_cur_loaded;
      w_combo      = r_combo;
      w_judge      = r_judge;

      case (r_state)
         ST_IDLE: begin
            // Presses here have nothing to judge and are ignored
            if (w_arrival) begin
               w_state    = ST_ARMED;
               w_cur_kind = note_kind;
               w_win_cnt  = c_WINDOW;
            end
         end

         ST_ARMED: begin
            if (w_don_rise && w_ka_rise) begin
               w_state = ST_WRONG;
            end else if (w_don_rise || w_ka_rise) begin
               w_state = (w_press_kind == r_cur_kind) ? ST_GOOD : ST_WRONG;
            end else if (w_arrival && r_pend_valid) begin
               // Queue overflow: the current note is given up
               w_state = ST_MISS;
            end else if (tick) begin
               if (r_win_cnt == 4'd1) w_state   = ST_MISS;
               else                   w_win_cnt = r_win_cnt - 4'd1;
            end

            // A note arriving with the pending slot full shifts the queue:
            // current is being resolved this cycle, so it takes the oldest
            // waiting note and the newest one becomes pending.
            if (w_arrival) begin
               if (r_pend_valid) begin
                  w_cur_kind   = r_pend_kind;
                  w_pend_kind  = note_kind;
                  w_cur_loaded = 1'b1;
               end else begin
                  w_pend_valid = 1'b1;
                  w_pend_kind  = note_kind;
               end
            end
         end

         ST_GOOD, ST_WRONG, ST_MISS: begin
            w_win_cnt = c_WINDOW;
            if (r_cur_loaded) begin
               // Current already holds the next note; a new arrival
               // replaces the waiting one
               w_state      = ST_ARMED;
               w_cur_loaded = 1'b0;
               if (w_arrival) begin
                  w_pend_valid = 1'b1;
                  w_pend_kind  = note_kind;
               end
            end else if (r_pend_valid) begin
               w_state    = ST_ARMED;
               w_cur_kind = r_pend_kind;
               if (w_arrival) w_pend_kind  = note_kind;
               else           w_pend_valid = 1'b0;
            end else if (w_arrival) begin
               w_state    = ST_ARMED;
               w_cur_kind = note_kind;
            end else begin
               w_state = ST_IDLE;
            end
         end

         default: w_state = ST_IDLE;
      endcase

      // Combo and judge change on entry to a resolution state so they are
      // visible alongside the score pulse
      if (r_state == ST_ARMED) begin
         case (w_state)
            ST_GOOD: begin
               w_judge = JUDGE_GOOD;
               if (r_combo != c_COMBO_MAX) w_combo = r_combo + 1'b1;
            end
            ST_WRONG: begin
               w_judge = JUDGE_WRONG;
               w_combo = '0;
            end
            ST_MISS: begin
               w_judge = JUDGE_MISS;
               w_combo = '0;
            end
            default: ;
         endcase
      end
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_cur_kind   <= KIND_DON;
         r_win_cnt    <= 4'd0;
         r_pend_valid <= 1'b0;
         r_pend_kind  <= KIND_DON;
         r_cur_loaded <= 1'b0;
         r_combo      <= '0;
         r_judge      <= JUDGE_NONE;
      end else begin
         r_state      <= w_state;
         r_cur_kind   <= w_cur_kind;
         r_win_cnt    <= w_win_cnt;
         r_pend_valid <= w_pend_valid;
         r_pend_kind  <= w_pend_kind;
         r_cur_loaded <= w_cur_loaded;
         r_combo      <= w_combo;
         r_judge      <= w_judge;
      end
   end

   assign increase_score = (r_state == ST_GOOD);
   assign decrease_score = (r_state == ST_WRONG) || (r_state == ST_MISS);
   assign busy           = (r_state != ST_IDLE);
   assign combo          = r_combo;
   assign judge          = r_judge;

endmodule : hit_judge_controller
`default_nettype wire

// File: tb/tb_hit_judge_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hit_judge_controller
//  Purpose  : Directed, table-driven bench for hit_judge_controller.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hit_judge_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic       tick, note_valid, note_kind, don_btn, ka_btn;
   logic       increase_score, decrease_score, busy;
   logic [7:0] combo;
   logic [1:0] judge;

   int n_vec  = 0;
   int n_fail = 0;

   hit_judge_controller #(.WINDOW(4), .COMBO_W(8)) dut (
      .clk            (clk),
      .reset          (reset),
      .tick           (tick),
      .note_valid     (note_valid),
      .note_kind      (note_kind),
      .don_btn        (don_btn),
      .ka_btn         (ka_btn),
      .increase_score (increase_score),
      .decrease_score (decrease_score),
      .combo          (combo),
      .judge          (judge),
      .busy           (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst, tk, nv, kd, dn, ka;
      logic       inc, dec;
      logic [7:0] cmb;
      logic [1:0] jd;
      logic       bz;
   } vec_t;

   vec_t vecs[38];

   function automatic vec_t mk(input logic rst, tk, nv, kd, dn, ka,
                               input logic inc, dec, input logic [7:0] cmb,
                               input logic [1:0] jd, input logic bz);
      vec_t v;
      v.rst = rst; v.tk = tk; v.nv = nv; v.kd = kd; v.dn = dn; v.ka = ka;
      v.inc = inc; v.dec = dec; v.cmb = cmb; v.jd = jd; v.bz = bz;
      return v;
   endfunction

   // Drive one cycle of inputs at the falling edge, sample 1 ns after the rise
   task automatic step(input logic rst, tk, nv, kd, dn, ka);
      @(negedge clk);
      reset = rst; tick = tk; note_valid = nv; note_kind = kd;
      don_btn = dn; ka_btn = ka;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic inc, dec,
                      input logic [7:0] cmb, input logic [1:0] jd, input logic bz);
      n_vec++;
      if (increase_score !== inc || decrease_score !== dec || combo !== cmb ||
          judge !== jd || busy !== bz) begin
         n_fail++;
         $display("FAIL %s: got inc=%b dec=%b combo=%0d judge=%b busy=%b, want inc=%b dec=%b combo=%0d judge=%b busy=%b",
                  name, increase_score, decrease_score, combo, judge, busy,
                  inc, dec, cmb, jd, bz);
      end
   endtask

   // Arm a don note, press don, release: one GOOD hit over three cycles
   task automatic good_hit(input string name, input logic [7:0] exp_combo);
      step(0, 1, 1, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0);
      chk(name, 1, 0, exp_combo, 2'b01, 1);
      step(0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      reset = 1'b1; tick = 0; note_valid = 0; note_kind = 0; don_btn = 0; ka_btn = 0;

      //               rst tk nv kd dn ka  inc dec cmb judge busy
      vecs[0]  = mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 2'b00, 0); // reset
      vecs[1]  = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 2'b00, 0);
      vecs[2]  = mk(0, 1, 1, 0, 0, 0,  0, 0, 0, 2'b00, 1); // don note arms
      vecs[3]  = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 2'b00, 1);
      vecs[4]  = mk(0, 1, 0, 0, 0, 0,  0, 0, 0, 2'b00, 1); // window 4->3
      vecs[5]  = mk(0, 0, 0, 0, 1, 0,  1, 0, 1, 2'b01, 1); // don -> GOOD
      vecs[6]  = mk(0, 0, 0, 0, 1, 0,  0, 0, 1, 2'b01, 0); // held, back to IDLE
      vecs[7]  = mk(0, 0, 0, 0, 0, 0,  0, 0, 1, 2'b01, 0);
      vecs[8]  = mk(0, 1, 1, 0, 0, 0,  0, 0, 1, 2'b01, 1); // don note
      vecs[9]  = mk(0, 0, 0, 0, 0, 1,  0, 1, 0, 2'b11, 1); // ka -> WRONG
      vecs[10] = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 2'b11, 0);
      vecs[11] = mk(0, 1, 1, 1, 0, 0,  0, 0, 0, 2'b11, 1); // ka note
      vecs[12] = mk(0, 0, 0, 0, 1, 1,  0, 1, 0, 2'b11, 1); // both -> WRONG
      vecs[13] = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 2'b11, 0);
      vecs[14] = mk(0, 0, 0, 0, 1, 0,  0, 0, 0, 2'b11, 0); // press in IDLE ignored
      vecs[15] = mk(0, 1, 1, 0, 0, 0,  0, 0, 0, 2'b11, 1); // don note, win=4
      vecs[16] = mk(0, 1, 0, 0, 0, 0,  0, 0, 0, 2'b11, 1); // 3
      vecs[17] = mk(0, 1, 0, 0, 0, 0,  0, 0, 0, 2'b11, 1); // 2
      vecs[18] = mk(0, 1, 0, 0, 0, 0,  0, 0, 0, 2'b11, 1); // 1
      vecs[19] = mk(0, 1, 0, 0, 0, 0,  0, 1, 0, 2'b10, 1); // 4th tick -> MISS
      vecs[20] = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 2'b10, 0);
      vecs[21] = mk(0, 1, 1, 0, 0, 0,  0, 0, 0, 2'b10, 1); // don note
      vecs[22] = mk(0, 1, 1, 1, 0, 0,  0, 0, 0, 2'b10, 1); // ka note -> pending
      vecs[23] = mk(0, 0, 0, 0, 1, 0,  1, 0, 1, 2'b01, 1); // GOOD
      vecs[24] = mk(0, 0, 0, 0, 0, 0,  0, 0, 1, 2'b01, 1); // pending promoted
      vecs[25] = mk(0, 0, 0, 0, 0, 1,  1, 0, 2, 2'b01, 1); // GOOD
      vecs[26] = mk(0, 0, 0, 0, 0, 0,  0, 0, 2, 2'b01, 0);
      vecs[27] = mk(0, 1, 1, 0, 0, 0,  0, 0, 2, 2'b01, 1); // note A don
      vecs[28] = mk(0, 1, 1, 1, 0, 0,  0, 0, 2, 2'b01, 1); // note B ka pending
      vecs[29] = mk(0, 1, 1, 0, 0, 0,  0, 1, 0, 2'b10, 1); // note C -> A MISSed
      vecs[30] = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 2'b10, 1); // B current
      vecs[31] = mk(0, 0, 0, 0, 0, 1,  1, 0, 1, 2'b01, 1); // ka hits B
      vecs[32] = mk(0, 0, 0, 0, 0, 0,  0, 0, 1, 2'b01, 1); // C current
      vecs[33] = mk(0, 0, 0, 0, 1, 0,  1, 0, 2, 2'b01, 1); // don hits C
      vecs[34] = mk(0, 0, 0, 0, 0, 0,  0, 0, 2, 2'b01, 0);
      vecs[35] = mk(0, 1, 1, 1, 0, 0,  0, 0, 2, 2'b01, 1); // ka note
      vecs[36] = mk(0, 1, 0, 0, 0, 1,  1, 0, 3, 2'b01, 1); // press+tick: press wins
      vecs[37] = mk(0, 0, 0, 0, 0, 0,  0, 0, 3, 2'b01, 0);

      for (int i = 0; i < 38; i++) begin
         step(vecs[i].rst, vecs[i].tk, vecs[i].nv, vecs[i].kd, vecs[i].dn, vecs[i].ka);
         chk($sformatf("vec%0d", i), vecs[i].inc, vecs[i].dec, vecs[i].cmb,
             vecs[i].jd, vecs[i].bz);
      end

      // Quiet period after reset
      step(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, 0);
      chk("quiet", 0, 0, 0, 2'b00, 0);

      // Build combo to 5, then let a note expire
      for (int i = 1; i <= 5; i++) good_hit($sformatf("build%0d", i), 8'(i));
      step(0, 1, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 0, 0, 0, 0);
         chk($sformatf("win_tick%0d", i + 1), 0, 0, 5, 2'b01, 1);
      end
      step(0, 1, 0, 0, 0, 0);
      chk("miss_clears_combo", 0, 1, 0, 2'b10, 1);
      step(0, 0, 0, 0, 0, 0);
      chk("miss_one_cycle", 0, 0, 0, 2'b10, 0);

      // Saturation
      for (int i = 1; i <= 300; i++)
         good_hit($sformatf("sat%0d", i), (i > 255) ? 8'd255 : 8'(i));
      chk("sat_final", 0, 0, 255, 2'b01, 0);

      // Asynchronous reset in the middle of a GOOD pulse
      step(0, 1, 1, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0);
      chk("pre_reset_good", 1, 0, 255, 2'b01, 1);
      #1 reset = 1'b1;
      #1 chk("async_reset", 0, 0, 0, 2'b00, 0);
      step(0, 0, 0, 0, 0, 0);
      chk("after_reset", 0, 0, 0, 2'b00, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule : tb_hit_judge_controller
`default_nettype wire
